ex_muldiv: RTL and testbench

//   Iterative RV32M multiply/divide unit in the EX stage. Consumes operands issued by
//   the ID/EX pipeline register, stalls the pipeline while computing, and returns the

---
 rtl/ex_muldiv.sv | 166 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit for the EX stage
// Shift-add multiply and restoring divide, one bit per cycle, one op in flight.
module ex_muldiv #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] opv1,
   input  logic [XLEN-1:0] opv2,
   input  logic [4:0]      waddr_i,
   input  logic            we_i,
   output logic            stallreq,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      waddr_o,
   output logic            we_o
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [2:0]        op_q;
   logic [XLEN-1:0]   b_q;
   logic [2*XLEN-1:0] acc_q;
   logic [CW-1:0]     cnt_q;
   logic              neg_q;
   logic [4:0]        waddr_q;
   logic              we_q;
   logic [XLEN-1:0]   result_q;
   logic [4:0]        waddr_o_q;

   // Operand decode on the issuing instruction
   logic            in_div, signed1, signed2, s1, s2, neg_in;
   logic [XLEN-1:0] mag1, mag2;
   logic            div_zero, div_ovf, fast;
   logic [XLEN-1:0] fast_val;

   always_comb begin
      in_div  = funct3[2];
      signed1 = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                (funct3 == 3'b100) || (funct3 == 3'b110);
      signed2 = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
      s1      = signed1 & opv1[XLEN-1];
      s2      = signed2 & opv2[XLEN-1];
      mag1    = s1 ? -opv1 : opv1;
      mag2    = s2 ? -opv2 : opv2;
      if (in_div)
         neg_in = funct3[1] ? s1 : (s1 ^ s2);
      else
         neg_in = s1 ^ s2;
      div_zero = in_div && (opv2 == '0);
      div_ovf  = in_div && !funct3[0] && (opv1 == MIN_NEG) && (&opv2);
      fast     = div_zero || div_ovf;
      fast_val = '0;
      if (div_zero)
         fast_val = funct3[1] ? opv1 : '1;
      else if (div_ovf)
         fast_val = funct3[1] ? '0 : MIN_NEG;
   end

   // One iteration of either algorithm; acc holds {hi, lo}
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic [XLEN+1:0]   div_diff;
   logic [2*XLEN-1:0] acc_nxt;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
      div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, b_q};
      if (!op_q[2])
         acc_nxt = {mul_sum, acc_q[XLEN-1:1]};
      else if (div_diff[XLEN+1])
         acc_nxt = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else
         acc_nxt = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
   end

   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo, rem, calc_res;
   logic              last;

   always_comb begin
      prod_s = neg_q ? -acc_nxt : acc_nxt;
      quo    = acc_nxt[XLEN-1:0];
      rem    = acc_nxt[2*XLEN-1:XLEN];
      last   = (cnt_q == CW'(XLEN - 1));
      case (op_q)
         3'b000:                 calc_res = prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: calc_res = prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:         calc_res = neg_q ? -quo : quo;
         default:                calc_res = neg_q ? -rem : rem;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = fast ? S_DONE : S_CALC;
         S_CALC: if (last)  state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state     <= S_IDLE;
         op_q      <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         waddr_q   <= '0;
         we_q      <= 1'b0;
         result_q  <= '0;
         waddr_o_q <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_q    <= funct3;
                  waddr_q <= waddr_i;
                  we_q    <= we_i;
                  neg_q   <= neg_in;
                  cnt_q   <= '0;
                  b_q     <= in_div ? mag2 : mag1;
                  acc_q   <= {{XLEN{1'b0}}, (in_div ? mag1 : mag2)};
                  if (fast) begin
                     result_q  <= fast_val;
                     waddr_o_q <= waddr_i;
                  end
               end
            end
            S_CALC: begin
               acc_q <= acc_nxt;
               cnt_q <= cnt_q + 1'b1;
               if (last) begin
                  result_q  <= calc_res;
                  waddr_o_q <= waddr_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign stallreq = !rst && !flush && (((state == S_IDLE) && start) || (state == S_CALC));
   assign done     = (state == S_DONE);
   assign we_o     = we_q && done;
   assign result   = result_q;
   assign waddr_o  = waddr_o_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - self-checking bench for ex_muldiv
// Vector table for results/latency plus hand sequences for stall, flush and reset.
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] opv1 = '0;
   logic [31:0] opv2 = '0;
   logic [4:0]  waddr_i = '0;
   logic        we_i = 1'b0;
   logic        stallreq, done, we_o;
   logic [31:0] result;
   logic [4:0]  waddr_o;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ex_muldiv #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .start(start), .funct3(funct3),
      .opv1(opv1), .opv2(opv2), .waddr_i(waddr_i), .we_i(we_i),
      .stallreq(stallreq), .done(done), .result(result), .waddr_o(waddr_o), .we_o(we_o)
   );

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[24];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input logic w, output int lat,
                         output logic [31:0] res, output logic [4:0] wao, output logic weo);
      @(negedge clk);
      start = 1'b1; funct3 = f; opv1 = a; opv2 = b; waddr_i = wa; we_i = w;
      @(posedge clk);
      #1;
      start = 1'b0; funct3 = ~f; opv1 = ~a; opv2 = ~b; waddr_i = ~wa; we_i = ~w;
      lat = -1; res = '0; wao = '0; weo = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (done) begin
            lat = c; res = result; wao = waddr_o; weo = we_o;
            break;
         end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          lat, stall_cnt, done_cnt, done_at;
      logic [31:0] res;
      logic [4:0]  wao;
      logic        weo;

      vecs[0]  = '{3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
      vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
      vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
      vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
      vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33};
      vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33};
      vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,        33};
      vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,         33};
      vecs[8]  = '{3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF, 1};
      vecs[9]  = '{3'b111, 32'd5,        32'd0,        32'd5,         1};
      vecs[10] = '{3'b101, 32'h10,       32'd0,        32'hFFFF_FFFF, 1};
      vecs[11] = '{3'b110, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 1};
      vecs[12] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[13] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
      vecs[14] = '{3'b000, 32'd3,        32'd4,        32'd12,        33};
      vecs[15] = '{3'b001, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 33};
      vecs[16] = '{3'b001, 32'd3,        32'd5,        32'd0,         33};
      vecs[17] = '{3'b100, 32'd20,       32'hFFFF_FFFD, 32'hFFFF_FFFA, 33};
      vecs[18] = '{3'b110, 32'd20,       32'hFFFF_FFFD, 32'd2,         33};
      vecs[19] = '{3'b110, 32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFE, 33};
      vecs[20] = '{3'b101, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 33};
      vecs[21] = '{3'b100, 32'h8000_0000, 32'd1,        32'h8000_0000, 33};
      vecs[22] = '{3'b011, 32'h8000_0000, 32'd2,        32'd1,         33};
      vecs[23] = '{3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33};

      // Reset state, with start asserted during reset
      start = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_stallreq", {31'd0, stallreq}, 32'd0);
      start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_we_o", {31'd0, we_o}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_waddr_o", {27'd0, waddr_o}, 32'd0);

      for (int i = 0; i < 24; i++) begin
         run_op(vecs[i].f, vecs[i].a, vecs[i].b, 5'(i + 1), i[0], lat, res, wao, weo);
         check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("vec%0d_result", i), res, vecs[i].exp);
         check($sformatf("vec%0d_waddr_o", i), {27'd0, wao}, 32'(i + 1));
         check($sformatf("vec%0d_we_o", i), {31'd0, weo}, {31'd0, i[0]});
      end

      // Stall window and start held high through DONE: exactly one done
      @(negedge clk);
      start = 1'b1; funct3 = 3'b000; opv1 = 32'd7; opv2 = 32'hFFFF_FFFD; waddr_i = 5'd9; we_i = 1'b1;
      stall_cnt = 0; done_cnt = 0; done_at = -1;
      for (int k = 0; k <= 33; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         if (stallreq) stall_cnt++;
         if (done) begin
            done_cnt++; done_at = k;
            check("held_result", result, 32'hFFFF_FFEB);
            check("held_stall_in_done", {31'd0, stallreq}, 32'd0);
         end
      end
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("held_stall_cycles", stall_cnt, 32'd33);
      check("held_done_cycle", done_at, 32'd33);
      check("held_done_count", done_cnt, 32'd1);

      // Flush mid-CALC, then a new op two cycles later
      @(negedge clk);
      start = 1'b1; funct3 = 3'b000; opv1 = 32'd5; opv2 = 32'd6; waddr_i = 5'd3; we_i = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 9) check("flush_pre_stall", {31'd0, stallreq}, 32'd1);
      end
      flush = 1'b1;
      #1;
      check("flush_stallreq", {31'd0, stallreq}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_done", {31'd0, done}, 32'd0);
      check("flush_we_o", {31'd0, we_o}, 32'd0);
      check("flush_stall_after", {31'd0, stallreq}, 32'd0);
      check("flush_result", result, 32'd0);
      run_op(3'b000, 32'd3, 32'd4, 5'd4, 1'b1, lat, res, wao, weo);
      check("post_flush_latency", lat, 32'd33);
      check("post_flush_result", res, 32'd12);

      // Flush together with start in IDLE: not accepted
      @(negedge clk);
      start = 1'b1; flush = 1'b1; funct3 = 3'b101; opv1 = 32'd9; opv2 = 32'd0;
      #1;
      check("flush_idle_stall", {31'd0, stallreq}, 32'd0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      done_cnt = 0;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (done || stallreq) done_cnt++;
         @(negedge clk);
      end
      check("flush_idle_no_accept", done_cnt, 32'd0);

      // Reset mid-op
      @(negedge clk);
      start = 1'b1; funct3 = 3'b101; opv1 = 32'd100; opv2 = 32'd7; waddr_i = 5'd17; we_i = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_we_o", {31'd0, we_o}, 32'd0);
      check("midrst_result", result, 32'd0);
      check("midrst_waddr_o", {27'd0, waddr_o}, 32'd0);
      check("midrst_stallreq", {31'd0, stallreq}, 32'd0);
      done_cnt = 0;
      for (int k = 0; k < 36; k++) begin
         @(negedge clk);
         if (done || stallreq) done_cnt++;
      end
      check("midrst_idle", done_cnt, 32'd0);
      run_op(3'b111, 32'd100, 32'd7, 5'd18, 1'b1, lat, res, wao, weo);
      check("post_rst_latency", lat, 32'd33);
      check("post_rst_result", res, 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
